// File: rtl/floor_call_register_if.sv
// Call-register bus: raw buttons and car status in, one-hot target and call summary out.
interface floor_call_register_if #(
   parameter int NUM_FLOORS = 3,
   parameter int FLOOR_W    = 2,
   parameter int CNT_W      = 2
);
   logic [NUM_FLOORS-1:0] btn;
   logic [FLOOR_W-1:0]    current_floor;
   logic                  door_open;
   logic [NUM_FLOORS-1:0] floor_req;
   logic                  req_pending;
   logic [CNT_W-1:0]      req_count;

   modport master (
      output btn, current_floor, door_open,
      input  floor_req, req_pending, req_count
   );

   modport slave (
      input  btn, current_floor, door_open,
      output floor_req, req_pending, req_count
   );
endinterface

// File: rtl/floor_call_register.sv
// Floor call register: per-floor debounce, call latching, served-call clearing
// and nearest-first target selection for the elevator controller.

// Single-button debouncer: pulses press on the D-th consecutive high sample.
module floor_call_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [DW-1:0] cnt;

   // The pulse fires only on the transition into saturation, so a held button latches once.
   always_comb press = btn && (cnt == DW'(DEBOUNCE_CYCLES - 1));

   // Count consecutive high samples, saturating; any low sample restarts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                             cnt <= '0;
      else if (!btn)                        cnt <= '0;
      else if (cnt != DW'(DEBOUNCE_CYCLES)) cnt <= cnt + DW'(1);
   end
endmodule

module floor_call_register #(
   parameter int NUM_FLOORS      = 3,
   parameter int FLOOR_W         = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CLEAR_HOLD      = 2,
   parameter int CNT_W           = 2
) (
   input logic                   clk,
   input logic                   rst,
   floor_call_register_if.slave  bus
);
   localparam int HW = $clog2(CLEAR_HOLD + 1);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t                state;
   logic [NUM_FLOORS-1:0] press, calls, calls_nxt, at_mask, clr_mask, floor_req_q;
   logic [FLOOR_W-1:0]    prev_floor, target, sel;
   logic [HW-1:0]         hold, hold_nxt;
   logic [CNT_W-1:0]      count;
   logic                  floor_ok;

   for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_db
      floor_call_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst   (rst),
         .btn   (bus.btn[g]),
         .press (press[g])
      );
   end

   // Door-open hold tracking and next call vector; a clear beats a same-edge set.
   always_comb begin
      floor_ok = int'(bus.current_floor) < NUM_FLOORS;
      at_mask  = (bus.door_open && floor_ok) ? (NUM_FLOORS'(1) << bus.current_floor) : '0;
      hold_nxt = '0;
      if (bus.door_open && floor_ok) begin
         // A floor change restarts the hold at 1 so the current cycle still counts.
         if (bus.current_floor != prev_floor) hold_nxt = HW'(1);
         else if (hold != HW'(CLEAR_HOLD))    hold_nxt = hold + HW'(1);
         else                                 hold_nxt = hold;
      end
      clr_mask  = (hold_nxt == HW'(CLEAR_HOLD)) ? at_mask : '0;
      // Presses at the floor where the door is open are already served.
      calls_nxt = (calls | (press & ~at_mask)) & ~clr_mask;
   end

   // Nearest pending call; ascending scan with strict compare lets the lower floor win ties.
   // An invalid car position makes every distance 0, so the lowest pending floor wins.
   always_comb begin
      int best;
      int d;
      sel  = '0;
      best = NUM_FLOORS + 1;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         d = 0;
         if (floor_ok)
            d = (i > int'(bus.current_floor)) ? i - int'(bus.current_floor)
                                               : int'(bus.current_floor) - i;
         if (calls[i] && d < best) begin
            best = d;
            sel  = FLOOR_W'(i);
         end
      end
   end

   // Popcount of latched calls.
   always_comb begin
      count = '0;
      for (int i = 0; i < NUM_FLOORS; i++) count = count + CNT_W'(calls[i]);
   end

   // Latched calls, door hold counter and last seen car position.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         calls      <= '0;
         hold       <= '0;
         prev_floor <= '0;
      end else begin
         calls      <= calls_nxt;
         hold       <= hold_nxt;
         prev_floor <= bus.current_floor;
      end
   end

   // Target FSM; selection only from IDLE forces a zero cycle between targets.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         target      <= '0;
         floor_req_q <= '0;
      end else begin
         case (state)
            IDLE: if (|calls) begin
               state       <= SERVE;
               target      <= sel;
               floor_req_q <= NUM_FLOORS'(1) << sel;
            end
            SERVE: if (!calls_nxt[target]) begin
               state       <= IDLE;
               floor_req_q <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.floor_req   = floor_req_q;
   assign bus.req_pending = |calls;
   assign bus.req_count   = count;
endmodule

// File: tb/tb_floor_call_register.sv
// Directed bench for floor_call_register: one task per scenario, inline checks.
module tb_floor_call_register;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   floor_call_register_if #(.NUM_FLOORS(3), .FLOOR_W(2), .CNT_W(2)) bus ();

   floor_call_register #(
      .NUM_FLOORS(3), .FLOOR_W(2), .DEBOUNCE_CYCLES(4), .CLEAR_HOLD(2), .CNT_W(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 2 ns after it.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0; bus.btn = 3'b000; bus.current_floor = 2'd0; bus.door_open = 1'b0;
      #3;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0; bus.btn = 3'b111; bus.current_floor = 2'd0; bus.door_open = 1'b0;
      tick(2);
      n_cmp++; if (bus.floor_req !== 3'b000) begin n_bad++; $display("FAIL rst_floor_req: got %b want 000", bus.floor_req); end
      n_cmp++; if (bus.req_pending !== 1'b0) begin n_bad++; $display("FAIL rst_pending: got %b want 0", bus.req_pending); end
      n_cmp++; if (bus.req_count !== 2'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", bus.req_count); end
      rst = 1'b1; bus.btn = 3'b100;
      tick(5);
      n_cmp++; if (bus.floor_req !== 3'b100) begin n_bad++; $display("FAIL rst_setup_serve: got %b want 100", bus.floor_req); end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (bus.floor_req !== 3'b000) begin n_bad++; $display("FAIL async_rst_floor_req: got %b want 000", bus.floor_req); end
      n_cmp++; if (bus.req_count !== 2'd0) begin n_bad++; $display("FAIL async_rst_count: got %0d want 0", bus.req_count); end
      n_cmp++; if (bus.req_pending !== 1'b0) begin n_bad++; $display("FAIL async_rst_pending: got %b want 0", bus.req_pending); end
      bus.btn = 3'b000;
      #2 rst = 1'b1;
      tick();
      n_cmp++; if (bus.floor_req !== 3'b000) begin n_bad++; $display("FAIL post_rst_floor_req: got %b want 000", bus.floor_req); end
   endtask

   task automatic test_debounce();
      do_reset();
      bus.btn = 3'b100;
      tick(3);
      bus.btn = 3'b000;
      tick();
      n_cmp++; if (bus.req_count !== 2'd0) begin n_bad++; $display("FAIL db_short_count: got %0d want 0", bus.req_count); end
      tick();
      n_cmp++; if (bus.floor_req !== 3'b000) begin n_bad++; $display("FAIL db_short_req: got %b want 000", bus.floor_req); end
      bus.btn = 3'b100;
      tick(3);
      n_cmp++; if (bus.req_count !== 2'd0) begin n_bad++; $display("FAIL db_edge3_count: got %0d want 0", bus.req_count); end
      tick();
      n_cmp++; if (bus.req_count !== 2'd1) begin n_bad++; $display("FAIL db_edge4_count: got %0d want 1", bus.req_count); end
      n_cmp++; if (bus.req_pending !== 1'b1) begin n_bad++; $display("FAIL db_edge4_pending: got %b want 1", bus.req_pending); end
      n_cmp++; if (bus.floor_req !== 3'b000) begin n_bad++; $display("FAIL db_edge4_req: got %b want 000", bus.floor_req); end
      tick();
      n_cmp++; if (bus.floor_req !== 3'b100) begin n_bad++; $display("FAIL db_edge5_req: got %b want 100", bus.floor_req); end
      // Held button stays latched once; new presses on 0 and 1 do not move the target.
      bus.btn = 3'b011;
      tick(4);
      n_cmp++; if (bus.req_count !== 2'd3) begin n_bad++; $display("FAIL db_more_count: got %0d want 3", bus.req_count); end
      n_cmp++; if (bus.floor_req !== 3'b100) begin n_bad++; $display("FAIL db_hold_req: got %b want 100", bus.floor_req); end
      bus.btn = 3'b000;
   endtask

   task automatic test_nearest();
      do_reset();
      bus.btn = 3'b110;
      tick(4);
      n_cmp++; if (bus.req_count !== 2'd2) begin n_bad++; $display("FAIL near_count: got %0d want 2", bus.req_count); end
      tick();
      n_cmp++; if (bus.floor_req !== 3'b010) begin n_bad++; $display("FAIL near_req: got %b want 010", bus.floor_req); end
      bus.btn = 3'b000; bus.current_floor = 2'd1; bus.door_open = 1'b1;
      tick();
      n_cmp++; if (bus.floor_req !== 3'b010) begin n_bad++; $display("FAIL near_hold1_req: got %b want 010", bus.floor_req); end
      tick();
      n_cmp++; if (bus.floor_req !== 3'b000) begin n_bad++; $display("FAIL near_clear_req: got %b want 000", bus.floor_req); end
      n_cmp++; if (bus.req_count !== 2'd1) begin n_bad++; $display("FAIL near_clear_count: got %0d want 1", bus.req_count); end
      bus.door_open = 1'b0;
      tick();
      n_cmp++; if (bus.floor_req !== 3'b100) begin n_bad++; $display("FAIL near_next_req: got %b want 100", bus.floor_req); end
   endtask

   task automatic test_tiebreak();
      do_reset();
      bus.current_floor = 2'd1; bus.btn = 3'b101;
      tick(5);
      n_cmp++; if (bus.floor_req !== 3'b001) begin n_bad++; $display("FAIL tie_req: got %b want 001", bus.floor_req); end
      n_cmp++; if (bus.req_count !== 2'd2) begin n_bad++; $display("FAIL tie_count: got %0d want 2", bus.req_count); end
      bus.btn = 3'b000;
   endtask

   task automatic test_hold_clear();
      do_reset();
      bus.btn = 3'b100;
      tick(5);
      bus.btn = 3'b001;
      tick(4);
      n_cmp++; if (bus.req_count !== 2'd2) begin n_bad++; $display("FAIL hold_setup_count: got %0d want 2", bus.req_count); end
      bus.btn = 3'b000; bus.current_floor = 2'd2; bus.door_open = 1'b1;
      tick();
      bus.door_open = 1'b0;
      tick();
      n_cmp++; if (bus.req_count !== 2'd2) begin n_bad++; $display("FAIL hold_short_count: got %0d want 2", bus.req_count); end
      n_cmp++; if (bus.floor_req !== 3'b100) begin n_bad++; $display("FAIL hold_short_req: got %b want 100", bus.floor_req); end
      bus.current_floor = 2'd0; bus.door_open = 1'b1;
      tick(2);
      n_cmp++; if (bus.req_count !== 2'd1) begin n_bad++; $display("FAIL opp_clear_count: got %0d want 1", bus.req_count); end
      n_cmp++; if (bus.floor_req !== 3'b100) begin n_bad++; $display("FAIL opp_clear_req: got %b want 100", bus.floor_req); end
      bus.door_open = 1'b0;
   endtask

   task automatic test_suppress_invalid();
      do_reset();
      bus.current_floor = 2'd0; bus.door_open = 1'b1; bus.btn = 3'b001;
      tick(4);
      n_cmp++; if (bus.req_count !== 2'd0) begin n_bad++; $display("FAIL supp_count: got %0d want 0", bus.req_count); end
      bus.btn = 3'b000; bus.door_open = 1'b0;
      tick();
      n_cmp++; if (bus.req_pending !== 1'b0) begin n_bad++; $display("FAIL supp_pending: got %b want 0", bus.req_pending); end
      n_cmp++; if (bus.floor_req !== 3'b000) begin n_bad++; $display("FAIL supp_req: got %b want 000", bus.floor_req); end
      bus.btn = 3'b111;
      tick(4);
      n_cmp++; if (bus.req_count !== 2'd3) begin n_bad++; $display("FAIL inv_setup_count: got %0d want 3", bus.req_count); end
      bus.btn = 3'b000; bus.current_floor = 2'd3; bus.door_open = 1'b1;
      tick(5);
      n_cmp++; if (bus.req_count !== 2'd3) begin n_bad++; $display("FAIL inv_no_clear_count: got %0d want 3", bus.req_count); end
      n_cmp++; if (bus.floor_req !== 3'b001) begin n_bad++; $display("FAIL inv_lowest_req: got %b want 001", bus.floor_req); end
      bus.door_open = 1'b0;
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_nearest();
      test_tiebreak();
      test_hold_clear();
      test_suppress_invalid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/floor_call_register.md
Name: floor_call_register

Overview:
Call-request front end for the elevator controller. Debounces the raw floor buttons, latches pending calls, and presents one target floor at a time as a one-hot floor_req to the controller. Watches current_floor/door_open coming back from the car and clears a call once it has been served. It is the producer of the controller's floor_req input.

Parameters:
NUM_FLOORS, 3, number of floors; width of btn and floor_req
FLOOR_W, 2, width of current_floor
DEBOUNCE_CYCLES, 4, consecutive high samples needed to accept a press
CLEAR_HOLD, 2, consecutive cycles door_open must be high at a floor to clear its call
CNT_W, 2, width of req_count (holds 0..NUM_FLOORS)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
btn  input  NUM_FLOORS  raw call buttons, bit i = floor i, synchronous to clk (synchronised upstream)
current_floor  input  FLOOR_W  car position, binary floor index
door_open  input  1  door-open status from the controller
floor_req  output  NUM_FLOORS  one-hot target floor to the controller, 0 = none
req_pending  output  1  OR of all latched calls
req_count  output  CNT_W  popcount of latched calls

Behaviour:
- Reset: rst low clears everything immediately, regardless of clk.
  - Cleared state: calls=0, debounce counters=0, hold counter=0, FSM=IDLE.
  - Outputs at reset: floor_req=0, req_pending=0, req_count=0.
  - Reset mid-serve drops all calls. The block resumes with rst high at the next edge.
- Debounce, per bit i:
  - Counter increments on each edge where btn[i] is sampled 1, saturating at DEBOUNCE_CYCLES.
  - Counter clears on any edge where btn[i] is sampled 0.
  - calls[i] is set on the edge where the counter reaches DEBOUNCE_CYCLES, i.e. on the D-th consecutive high sample.
  - A held button sets the call only once. A new call requires a release first.
- Press suppression: a press that completes while door_open=1 and current_floor==i is discarded. Clear wins over set on the same bit.
- Clear logic:
  - Hold counter increments each edge with door_open=1 and current_floor < NUM_FLOORS.
  - Hold counter resets to 0 when door_open=0 or current_floor changes.
  - On reaching CLEAR_HOLD, calls[current_floor] is cleared on that edge.
  - Clearing applies to any floor, target or not, so en-route stops are served opportunistically.
  - current_floor >= NUM_FLOORS (e.g. 2'b11) never clears and never suppresses.
- Target FSM, registered outputs:
  - IDLE: floor_req=0. If calls!=0 at an edge, select the target and enter SERVE. floor_req becomes onehot(target) at that same edge.
  - Selection rule: the nearest pending call by |i - current_floor|. On a tie, the lower floor wins. If current_floor is invalid, the lowest pending floor wins.
  - SERVE: floor_req holds onehot(target), stable even if new calls arrive. When calls[target] is cleared, go to IDLE and drive floor_req=0 on that edge.
  - Re-selection from IDLE happens on the following edge at the earliest. This guarantees at least one cycle of floor_req=0 between targets.
- Latency, from the first high sample of btn:
  - calls bit set at edge D.
  - floor_req valid at edge D+1 (when in IDLE).
  - req_pending and req_count change at edge D.
- Width rules: req_count is a popcount of NUM_FLOORS bits. It never wraps, since CNT_W is sized to hold NUM_FLOORS.
- Simultaneous presses on multiple floors within the same edge all latch. Target selection then applies the nearest rule.

Test Plan:
1. Reset: drive rst=0 with btn=111 held -> floor_req=000, req_pending=0, req_count=0. Assert rst=0 asynchronously while in SERVE with floor_req=100 -> floor_req=000 before the next edge.
2. Debounce: btn=100 for 3 cycles then 000 -> no call. btn=100 for 4 cycles -> req_count=1 at the 4th edge, floor_req=100 one edge later, held across further presses.
3. Nearest selection: current_floor=00, btn=110 pressed together for 4 cycles -> floor_req=010, req_count=2. Then current_floor=01 with door_open=1 for 2 cycles -> call1 cleared, floor_req=000 for one cycle, then floor_req=100, req_count=1.
4. Tie-break: current_floor=01, btn=101 for 4 cycles -> floor_req=001.
5. Hold and opportunistic clear:
   - door_open=1 for 1 cycle at the target floor -> no clear.
   - Target=2 with call0 pending, current_floor=00, door_open=1 for 2 cycles -> call0 cleared, req_count 2->1, floor_req stays 100.
6. Suppression and invalid floor:
   - btn=001 for 4 cycles while door_open=1 and current_floor=00 -> no call latched.
   - current_floor=11 with door_open=1 for 5 cycles and calls pending -> nothing cleared.
